// File: rtl/str_to_int_pkg.sv
// Shared definitions for the ASCII decimal parser: character codes,
// parser state encoding and a digit classifier.
package str_to_int_pkg;

    localparam logic [7:0] CH_0     = 8'h30;
    localparam logic [7:0] CH_9     = 8'h39;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_NL    = 8'h0A;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SIGN   = 2'd1,
        DIGITS = 2'd2,
        DONE   = 2'd3
    } state_e;

    // True for ASCII '0'..'9'.
    function automatic logic is_digit(input logic [7:0] ch);
        return (ch >= CH_0) && (ch <= CH_9);
    endfunction

endpackage

// File: rtl/dec_mac_sat.sv
// Combinational decimal multiply-accumulate: acc*10 + digit, clamped to
// the all-ones value of WIDTH bits with an overflow flag.
module dec_mac_sat #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [3:0]       digit,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    logic [WIDTH+3:0] acc_ext_s;
    logic [WIDTH+3:0] dig_ext_s;
    logic [WIDTH+3:0] sum_s;

    // Four spare bits hold acc*10+9 for any acc, so the upper nibble alone
    // tells whether the true result exceeds the WIDTH-bit range.
    always_comb begin
        acc_ext_s = {4'b0000, acc};
        dig_ext_s = {{WIDTH{1'b0}}, digit};
        sum_s     = (acc_ext_s << 3'd3) + (acc_ext_s << 3'd1) + dig_ext_s;
        ovf       = |sum_s[WIDTH+3:WIDTH];
        if (ovf) begin
            result = {WIDTH{1'b1}};
        end else begin
            result = sum_s[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/ascii_dec_to_int.sv
// Streaming ASCII decimal to two's-complement integer parser. Optional
// leading spaces and '-' sign, then digits, ended by any non-digit.
module ascii_dec_to_int
    import str_to_int_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       char_i,
    input  logic             char_valid_i,
    output logic             char_ready_o,
    output logic [WIDTH-1:0] value_o,
    output logic             value_valid_o,
    input  logic             value_ready_i,
    output logic             ovf_o,
    output logic             err_o,
    output logic [CNT_W-1:0] ndigits_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [WIDTH-1:0] VAL_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_r, state_s;
    logic [WIDTH-1:0] acc_r, acc_s;
    logic             neg_r, neg_s;
    logic             ovf_r, ovf_s;
    logic             err_r, err_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;

    logic             take_s;
    logic [WIDTH-1:0] digit_ext_s;
    logic [WIDTH-1:0] mac_acc_s;
    logic             mac_ovf_s;

    assign take_s      = char_valid_i && (state_r != DONE);
    assign digit_ext_s = {{(WIDTH-4){1'b0}}, char_i[3:0]};

    dec_mac_sat #(
        .WIDTH (WIDTH)
    ) u_mac (
        .acc    (acc_r),
        .digit  (char_i[3:0]),
        .result (mac_acc_s),
        .ovf    (mac_ovf_s)
    );

    // State and datapath registers; reset drops any partial parse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            acc_r   <= {WIDTH{1'b0}};
            neg_r   <= 1'b0;
            ovf_r   <= 1'b0;
            err_r   <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            acc_r   <= acc_s;
            neg_r   <= neg_s;
            ovf_r   <= ovf_s;
            err_r   <= err_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state and next-datapath decode for one accepted character.
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        neg_s   = neg_r;
        ovf_s   = ovf_r;
        err_s   = err_r;
        cnt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (take_s) begin
                    if (is_digit(char_i)) begin
                        acc_s   = digit_ext_s;
                        cnt_s   = CNT_ONE;
                        state_s = DIGITS;
                    end else if (char_i == CH_SPACE) begin
                        state_s = IDLE;
                    end else if (char_i == CH_MINUS) begin
                        neg_s   = 1'b1;
                        state_s = SIGN;
                    end else begin
                        err_s   = 1'b1;
                        state_s = DONE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SIGN: begin
                if (take_s) begin
                    if (is_digit(char_i)) begin
                        acc_s   = digit_ext_s;
                        cnt_s   = CNT_ONE;
                        state_s = DIGITS;
                    end else begin
                        err_s   = 1'b1;
                        state_s = DONE;
                    end
                end else begin
                    state_s = SIGN;
                end
            end
            DIGITS: begin
                if (take_s) begin
                    if (is_digit(char_i)) begin
                        acc_s = mac_acc_s;
                        ovf_s = ovf_r | mac_ovf_s;
                        if (cnt_r != CNT_MAX) begin
                            cnt_s = cnt_r + CNT_ONE;
                        end else begin
                            cnt_s = cnt_r;
                        end
                        state_s = DIGITS;
                    end else begin
                        // Any non-digit terminates the number and is consumed.
                        state_s = DONE;
                    end
                end else begin
                    state_s = DIGITS;
                end
            end
            DONE: begin
                if (value_ready_i) begin
                    acc_s   = {WIDTH{1'b0}};
                    neg_s   = 1'b0;
                    ovf_s   = 1'b0;
                    err_s   = 1'b0;
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                acc_s   = {WIDTH{1'b0}};
                neg_s   = 1'b0;
                ovf_s   = 1'b0;
                err_s   = 1'b0;
                cnt_s   = {CNT_W{1'b0}};
                state_s = IDLE;
            end
        endcase
    end

    // Outputs decoded purely from registers, so they hold steady in DONE.
    always_comb begin
        char_ready_o  = (state_r != DONE);
        value_valid_o = (state_r == DONE);
        ovf_o         = ovf_r;
        err_o         = err_r;
        ndigits_o     = cnt_r;
        if ((state_r == DONE) && !err_r) begin
            if (neg_r) begin
                value_o = ~acc_r + VAL_ONE;
            end else begin
                value_o = acc_r;
            end
        end else begin
            value_o = {WIDTH{1'b0}};
        end
    end

endmodule

// File: doc/ascii_dec_to_int.md
Name: ascii_dec_to_int

Overview:
Streaming ASCII-decimal-to-integer parser: the hardware inverse of the team's integer-to-string (itoa) formatting.
- Consumes one ASCII character per cycle over a valid/ready interface.
- Accepts optional leading spaces and an optional '-' sign, then decimal digits.
- Emits a WIDTH-bit two's-complement integer when a terminator character arrives.
- Sits between a character source (UART RX, file-playback BFM, log scanner) and scoreboard or register logic that needs numeric values.

Parameters:
WIDTH, 32, bit width of result; values are interpreted mod 2^WIDTH.
CNT_W, 5, width of the digit counter; saturates at 2^CNT_W-1.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
char_i  in  8  ASCII character.
char_valid_i  in  1  char_i valid.
char_ready_o  out  1  parser can accept char_i this cycle.
value_o  out  WIDTH  parsed result (two's complement).
value_valid_o  out  1  result valid; held until accepted.
value_ready_i  in  1  consumer accepts result.
ovf_o  out  1  magnitude saturated during parse; qualified by value_valid_o.
err_o  out  1  malformed input; qualified by value_valid_o.
ndigits_o  out  CNT_W  number of digits consumed; qualified by value_valid_o.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; acc=0; neg=0; all outputs 0 except char_ready_o=1 after the reset cycle. Reset mid-parse discards partial state with no output.
- Character transfer occurs when char_valid_i & char_ready_o. char_ready_o = (state != DONE).
- Digit = 0x30..0x39; space = 0x20; terminator = any non-digit seen in DIGITS.
- FSM:
  - IDLE:
    - space: stay.
    - '-' (0x2D): neg=1, go to SIGN.
    - digit: acc=d, go to DIGITS.
    - other: err=1, go to DONE (character consumed).
  - SIGN:
    - digit: acc=d, go to DIGITS.
    - other: err=1, go to DONE.
  - DIGITS:
    - digit: acc=acc*10+d, go to DIGITS.
    - non-digit: consumed as terminator, go to DONE.
  - DONE:
    - value_valid_o=1.
    - On value_ready_i: clear acc/neg/ovf/err/count, go to IDLE next cycle.
- Latency: terminator accepted at edge N → value_valid_o=1 after edge N. Throughput is one character per cycle, plus one DONE cycle per number minimum.
- Arithmetic:
  - acc*10 computed as (acc<<3)+(acc<<1) in WIDTH+4 bits, plus d.
  - If result > 2^WIDTH-1: acc=2^WIDTH-1, ovf sticky=1, further digits are still consumed and counted.
  - value_o = neg ? (~acc+1) mod 2^WIDTH : acc. No signed-range check; "-0" gives 0.
- value_o, ovf_o, err_o and ndigits_o are stable while value_valid_o=1. value_o=0 when err=1.
- Simultaneous value_ready_i and incoming char in DONE: the char is not accepted (ready=0); it is taken in IDLE the next cycle.
- char_valid_i low: no state change. Input char_i is ignored when char_valid_i=0.

Decomposition:
- Package str_to_int_pkg:
  - ASCII constants: CH_0, CH_9, CH_SPACE, CH_MINUS, CH_NL.
  - State enum: IDLE, SIGN, DIGITS, DONE.
  - Function is_digit().
- One sub-module, dec_mac_sat:
  - Combinational acc*10+d with saturation and ovf flag.
  - Parameterised by WIDTH.
  - Reusable by a future hex/dec parser.

Test Plan:
- Stream "10\n" with value_ready_i=1 → value_o=10, ndigits_o=2, err_o=0, ovf_o=0, valid 1 cycle after '\n'.
- Stream "  3 ", then "65535\n" back-to-back → 3, then 0x0000FFFF. char_ready_o is low exactly one cycle between the two numbers.
- Stream "-1 " → value_o=0xFFFFFFFF. Stream "-0 " → value_o=0.
- Stream "4294967296\n" → value_o=0xFFFFFFFF, ovf_o=1, ndigits_o=10. Stream "4294967295\n" → same value, ovf_o=0.
- Stream "x" → err_o=1, value_o=0. Stream "-a" → err_o=1. Hold value_ready_i=0 for 5 cycles → outputs stable, char_ready_o=0 throughout.
- Assert rst after "12" mid-parse, then stream "7\n" → only value 7 is reported. No output for the discarded partial parse.
